// File: rtl/fir_preemphasis.sv
// Transmit pre-emphasis: y[n] = B0*x[n] + B1*x[n-1] in Q10, one shared multiplier
// used over two cycles, 32-bit saturated result streamed FIFO-to-FIFO.
module fir_preemphasis #(
  parameter int                            DATA_WIDTH = 32,
  parameter int                            FRAC_BITS  = 10,
  parameter logic signed [DATA_WIDTH-1:0]  B0         = 1024,
  parameter logic signed [DATA_WIDTH-1:0]  B1         = -666
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_dout,
  input  logic                  in_empty,
  output logic                  in_rd_en,
  output logic [DATA_WIDTH-1:0] out_din,
  output logic                  out_wr_en,
  input  logic                  out_full
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam int AW = DATA_WIDTH + 2;
  localparam int HW = AW - DATA_WIDTH + 1;

  typedef enum logic [1:0] {READ, MAC0, MAC1, WRITE} state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] x_cur, x_prev;
  logic [AW-1:0]         acc;
  logic                  take, load_out, rd_go, wr_go;

  logic [DATA_WIDTH-1:0] mul_a, mul_b;
  logic [PW-1:0]         prod;
  logic [DATA_WIDTH-1:0] mul_q;
  logic [AW-1:0]         mul_ext, acc_sum;
  logic [DATA_WIDTH-1:0] sat_q;
  logic                  unused_prod;

  // One multiplier: MAC0 uses (x_cur, B0), MAC1 uses (x_prev, B1).
  assign mul_a = (state == MAC1) ? x_prev : x_cur;
  assign mul_b = (state == MAC1) ? B1 : B0;

  // Low 2*W bits of the sign-extended product equal the signed product, and
  // the kept slice lies entirely inside them, so an unsigned multiply suffices.
  assign prod = {{DATA_WIDTH{mul_a[DATA_WIDTH-1]}}, mul_a}
              * {{DATA_WIDTH{mul_b[DATA_WIDTH-1]}}, mul_b};
  assign mul_q   = prod[FRAC_BITS +: DATA_WIDTH];
  assign mul_ext = {{(AW-DATA_WIDTH){mul_q[DATA_WIDTH-1]}}, mul_q};
  assign acc_sum = acc + mul_ext;

  assign unused_prod = ^{prod[PW-1:FRAC_BITS+DATA_WIDTH], prod[FRAC_BITS-1:0]};

  always_comb begin
    sat_q = acc_sum[DATA_WIDTH-1:0];
    if (acc_sum[AW-1:DATA_WIDTH-1] != {HW{acc_sum[AW-1]}})
      sat_q = acc_sum[AW-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                            : {1'b0, {(DATA_WIDTH-1){1'b1}}};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= READ;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    load_out  = 1'b0;
    wr_go     = 1'b0;
    unique case (state)
      READ: begin
        if (!in_empty) begin
          take      = 1'b1;
          state_nxt = MAC0;
        end
      end
      MAC0: state_nxt = MAC1;
      MAC1: begin
        load_out  = 1'b1;
        state_nxt = WRITE;
      end
      WRITE: begin
        // Backpressure holds everything, including the input side.
        if (!out_full) begin
          wr_go = 1'b1;
          if (!in_empty) begin
            take      = 1'b1;
            state_nxt = MAC0;
          end else begin
            state_nxt = READ;
          end
        end
      end
      default: state_nxt = READ;
    endcase
  end

  // Enables are forced low while reset is held so no FIFO traffic leaks through.
  assign rd_go     = take & ~reset;
  assign in_rd_en  = rd_go;
  assign out_wr_en = wr_go & ~reset;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x_cur   <= '0;
      x_prev  <= '0;
      acc     <= '0;
      out_din <= '0;
    end else begin
      if (take) begin
        x_prev <= x_cur;
        x_cur  <= in_dout;
        acc    <= '0;
      end else if (state == MAC0) begin
        acc <= acc_sum;
      end
      if (load_out) out_din <= sat_q;
    end
  end

endmodule

// File: tb/tb_fir_preemphasis.sv
// Bench for fir_preemphasis: FIFO models on both sides, scoreboard against a
// plain-arithmetic model of y[n] = sat(B0*x[n] + B1*x[n-1]).
module tb_fir_preemphasis;

  logic        clock, reset, in_empty, in_rd_en, out_wr_en, out_full;
  logic [31:0] in_dout, out_din;

  logic [31:0] in_q[$], popped[$], got[$];
  int          pop_cyc[$], wr_cyc[$];
  int          cyc, total, bad, full_pct, gap_pct;
  bit          full_hold;

  fir_preemphasis dut (
    .clock    (clock),
    .reset    (reset),
    .in_dout  (in_dout),
    .in_empty (in_empty),
    .in_rd_en (in_rd_en),
    .out_din  (out_din),
    .out_wr_en(out_wr_en),
    .out_full (out_full)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] ref_y(input logic [31:0] x, input logic [31:0] xp);
    longint a, b, s;
    longint maxv, minv;
    maxv = 64'sd2147483647;
    minv = -64'sd2147483648;
    a = (longint'($signed(x)) * 1024) >>> 10;
    b = (longint'($signed(xp)) * -666) >>> 10;
    a = longint'(int'(a));
    b = longint'(int'(b));
    s = a + b;
    if (s > maxv) s = maxv;
    else if (s < minv) s = minv;
    return s[31:0];
  endfunction

  function automatic void model_stream(input logic [31:0] xs[$], output logic [31:0] ys[$]);
    logic [31:0] prev;
    prev = 32'h0;
    ys = {};
    foreach (xs[i]) begin
      ys.push_back(ref_y(xs[i], prev));
      prev = xs[i];
    end
  endfunction

  task automatic update_inputs();
    out_full = full_hold || (int'($urandom_range(99)) < full_pct);
    in_empty = (in_q.size() == 0) || (int'($urandom_range(99)) < gap_pct);
    in_dout  = (in_q.size() != 0) ? in_q[0] : 32'h0;
  endtask

  task automatic sample();
    cyc++;
    if (in_rd_en) begin
      popped.push_back(in_dout);
      pop_cyc.push_back(cyc);
      if (in_q.size() != 0) void'(in_q.pop_front());
    end
    if (out_wr_en) begin
      got.push_back(out_din);
      wr_cyc.push_back(cyc);
    end
  endtask

  // Inputs change just after the rising edge, outputs are observed on the falling edge.
  task automatic step();
    @(posedge clock); #1;
    update_inputs();
    @(negedge clock);
    sample();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_q = {}; popped = {}; got = {}; pop_cyc = {}; wr_cyc = {};
    full_hold = 1'b0; full_pct = 0; gap_pct = 0;
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b0;
    update_inputs();
    @(negedge clock);
    sample();
  endtask

  task automatic run_until(input int n, input int budget, output bit to);
    int k;
    k = 0;
    while (got.size() < n && k < budget) begin
      step();
      k++;
    end
    to = (got.size() < n);
  endtask

  task automatic test_reset();
    in_empty = 1'b0; in_dout = 32'h1234_5678; out_full = 1'b0;
    #2;
    total++; if (in_rd_en !== 1'b0) begin bad++; $display("FAIL reset_rd_en got=%b want=0", in_rd_en); end
    total++; if (out_wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en got=%b want=0", out_wr_en); end
    total++; if (out_din !== 32'h0) begin bad++; $display("FAIL reset_out_din got=%h want=0", out_din); end
    do_reset();
    total++; if (in_rd_en !== 1'b0) begin bad++; $display("FAIL idle_rd_en got=%b want=0", in_rd_en); end
  endtask

  task automatic test_latency();
    bit to;
    do_reset();
    in_q.push_back(32'd1024);
    run_until(1, 50, to);
    total++;
    if (to) begin bad++; $display("FAIL latency_timeout got=%0d want=1 writes", got.size()); end
    else begin
      total++; if (got[0] !== 32'd1024) begin bad++; $display("FAIL latency_value got=%h want=%h", got[0], 32'd1024); end
      total++; if (wr_cyc[0] - pop_cyc[0] !== 3) begin bad++; $display("FAIL latency_cycles got=%0d want=3", wr_cyc[0] - pop_cyc[0]); end
    end
  endtask

  task automatic test_basic();
    bit to;
    logic [31:0] want[3];
    want[0] = 32'd1024; want[1] = 32'd358; want[2] = 32'hFFFF_F566;  // -2714
    do_reset();
    in_q = {32'd1024, 32'd1024, 32'hFFFF_F800};
    run_until(3, 100, to);
    total++;
    if (to) begin bad++; $display("FAIL basic_timeout got=%0d want=3 writes", got.size()); end
    else for (int i = 0; i < 3; i++) begin
      total++;
      if (got[i] !== want[i]) begin bad++; $display("FAIL basic_out[%0d] got=%h want=%h", i, got[i], want[i]); end
    end
  endtask

  task automatic test_rounding();
    bit to;
    do_reset();
    in_q = {32'd1, 32'd1};
    run_until(2, 100, to);
    total++;
    if (to) begin bad++; $display("FAIL round_timeout got=%0d want=2 writes", got.size()); end
    else begin
      total++; if (got[0] !== 32'd1) begin bad++; $display("FAIL round_out0 got=%h want=1", got[0]); end
      total++; if (got[1] !== 32'd0) begin bad++; $display("FAIL round_out1 got=%h want=0", got[1]); end
    end
  endtask

  task automatic test_saturation();
    bit to;
    do_reset();
    in_q = {32'h8000_0000, 32'h7FFF_FFFF};
    run_until(2, 100, to);
    total++;
    if (to) begin bad++; $display("FAIL sat_hi_timeout got=%0d want=2 writes", got.size()); end
    else begin
      total++; if (got[0] !== 32'h8000_0000) begin bad++; $display("FAIL sat_hi_out0 got=%h want=80000000", got[0]); end
      total++; if (got[1] !== 32'h7FFF_FFFF) begin bad++; $display("FAIL sat_hi_out1 got=%h want=7fffffff", got[1]); end
    end
    do_reset();
    in_q = {32'h7FFF_FFFF, 32'h8000_0000};
    run_until(2, 100, to);
    total++;
    if (to) begin bad++; $display("FAIL sat_lo_timeout got=%0d want=2 writes", got.size()); end
    else begin
      total++; if (got[0] !== 32'h7FFF_FFFF) begin bad++; $display("FAIL sat_lo_out0 got=%h want=7fffffff", got[0]); end
      total++; if (got[1] !== 32'h8000_0000) begin bad++; $display("FAIL sat_lo_out1 got=%h want=80000000", got[1]); end
    end
  endtask

  task automatic test_back_to_back();
    bit to;
    logic [31:0] xs[$], ys[$];
    do_reset();
    for (int i = 0; i < 6; i++) xs.push_back($urandom);
    in_q = xs;
    run_until(6, 200, to);
    total++;
    if (to) begin bad++; $display("FAIL b2b_timeout got=%0d want=6 writes", got.size()); end
    else begin
      for (int i = 1; i < 6; i++) begin
        total++;
        if (pop_cyc[i] - pop_cyc[i-1] !== 3) begin bad++; $display("FAIL b2b_interval[%0d] got=%0d want=3", i, pop_cyc[i] - pop_cyc[i-1]); end
      end
      // Next sample arrives one cycle after the write: goes through READ.
      xs.push_back($urandom);
      in_q.push_back(xs[6]);
      run_until(7, 50, to);
      total++;
      if (to) begin bad++; $display("FAIL gap_timeout got=%0d want=7 writes", got.size()); end
      else begin
        total++;
        if (pop_cyc[6] - pop_cyc[5] !== 4) begin bad++; $display("FAIL gap_interval got=%0d want=4", pop_cyc[6] - pop_cyc[5]); end
        model_stream(xs, ys);
        for (int i = 0; i < 7; i++) begin
          total++;
          if (got[i] !== ys[i]) begin bad++; $display("FAIL b2b_out[%0d] got=%h want=%h", i, got[i], ys[i]); end
        end
      end
    end
  endtask

  task automatic test_backpressure();
    bit to;
    int k;
    logic [31:0] din0;
    logic [31:0] xs[$], ys[$];
    do_reset();
    full_hold = 1'b1;
    xs = {32'd100, 32'd200, 32'd300};
    in_q = xs;
    model_stream(xs, ys);
    k = 0;
    while (popped.size() < 1 && k < 20) begin step(); k++; end
    step(); step(); step();
    din0 = out_din;
    total++; if (din0 !== ys[0]) begin bad++; $display("FAIL bp_stall_value got=%h want=%h", din0, ys[0]); end
    for (int i = 0; i < 10; i++) begin
      if (i > 0) step();
      total++; if (in_rd_en !== 1'b0) begin bad++; $display("FAIL bp_rd_en[%0d] got=%b want=0", i, in_rd_en); end
      total++; if (out_wr_en !== 1'b0) begin bad++; $display("FAIL bp_wr_en[%0d] got=%b want=0", i, out_wr_en); end
      total++; if (out_din !== din0) begin bad++; $display("FAIL bp_din_stable[%0d] got=%h want=%h", i, out_din, din0); end
    end
    full_hold = 1'b0;
    step();
    total++; if (got.size() !== 1) begin bad++; $display("FAIL bp_release_writes got=%0d want=1", got.size()); end
    total++; if (popped.size() !== 2) begin bad++; $display("FAIL bp_release_pops got=%0d want=2", popped.size()); end
    run_until(3, 100, to);
    total++;
    if (to) begin bad++; $display("FAIL bp_timeout got=%0d want=3 writes", got.size()); end
    else for (int i = 0; i < 3; i++) begin
      total++;
      if (got[i] !== ys[i]) begin bad++; $display("FAIL bp_out[%0d] got=%h want=%h", i, got[i], ys[i]); end
    end
  endtask

  task automatic test_random();
    bit to;
    logic [31:0] xs[$], ys[$];
    do_reset();
    for (int i = 0; i < 100; i++) begin
      if (i % 10 == 3)      xs.push_back(32'h7FFF_FFFF);
      else if (i % 10 == 4) xs.push_back(32'h8000_0000);
      else if (i % 10 == 7) xs.push_back($urandom_range(4095));
      else                  xs.push_back($urandom);
    end
    model_stream(xs, ys);
    in_q = xs;
    full_pct = 30;
    gap_pct = 25;
    run_until(100, 5000, to);
    total++;
    if (to || got.size() != 100) begin bad++; $display("FAIL rand_count got=%0d want=100", got.size()); end
    else for (int i = 0; i < 100; i++) begin
      total++;
      if (popped[i] !== xs[i]) begin bad++; $display("FAIL rand_pop[%0d] got=%h want=%h", i, popped[i], xs[i]); end
      total++;
      if (got[i] !== ys[i]) begin bad++; $display("FAIL rand_out[%0d] got=%h want=%h", i, got[i], ys[i]); end
    end
  endtask

  task automatic test_reset_mac1();
    bit to;
    do_reset();
    in_q = {32'd5000, 32'd7000, 32'd9000};
    run_until(1, 50, to);
    total++; if (to || popped.size() != 2) begin bad++; $display("FAIL rmac_setup got=%0d want=2 pops", popped.size()); end
    @(posedge clock); #1; update_inputs();   // MAC0
    @(posedge clock); #1; update_inputs();   // MAC1
    #1;
    total++; if (out_din !== 32'd5000) begin bad++; $display("FAIL rmac_pre_din got=%h want=%h", out_din, 32'd5000); end
    reset = 1'b1;
    #1;
    total++; if (out_din !== 32'h0) begin bad++; $display("FAIL rmac_din got=%h want=0", out_din); end
    total++; if (out_wr_en !== 1'b0) begin bad++; $display("FAIL rmac_wr_en got=%b want=0", out_wr_en); end
    total++; if (in_rd_en !== 1'b0) begin bad++; $display("FAIL rmac_rd_en got=%b want=0", in_rd_en); end
    do_reset();
    in_q.push_back(32'd9000);
    run_until(1, 50, to);
    total++;
    if (to) begin bad++; $display("FAIL rmac_timeout got=%0d want=1 writes", got.size()); end
    else begin
      total++;
      if (got[0] !== ref_y(32'd9000, 32'd0)) begin bad++; $display("FAIL rmac_history got=%h want=%h", got[0], ref_y(32'd9000, 32'd0)); end
    end
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0;
    full_hold = 1'b0; full_pct = 0; gap_pct = 0;
    reset = 1'b1; in_empty = 1'b1; in_dout = 32'h0; out_full = 1'b0;
    test_reset();
    test_latency();
    test_basic();
    test_rounding();
    test_saturation();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_mac1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fir_preemphasis.md
# fir_preemphasis

Transmit-side pre-emphasis filter for the FM chain. It sits between the audio source FIFO and the FM modulator FIFO and is the complement of the receive-path de-emphasis stage. It computes y[n] = B0·x[n] + B1·x[n-1] in Q10 fixed point, sharing one multiplier across two cycles. The result saturates to 32-bit signed and streams FIFO-to-FIFO with read/write handshakes.

## Interface
- DATA_WIDTH, 32: sample width, two's-complement; only 32 is supported.
- FRAC_BITS, 10: fractional bits of the coefficients and of the multiply shift.
- B0, 1024: current-sample coefficient, signed Q10 (1.0).
- B1, -666: previous-sample coefficient, signed Q10 (≈ -0.650, mirrors the de-emphasis pole).
- clock  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-high.
- in_dout  input  32  head-of-FIFO input sample (first-word-fall-through).
- in_empty  input  1  input FIFO empty.
- in_rd_en  output  1  pops input FIFO this cycle; combinational.
- out_din  output  32  filtered sample; driven from a register.
- out_wr_en  output  1  pushes out_din into output FIFO this cycle; combinational.
- out_full  input  1  output FIFO full.

## Operation
- Multiply: mul(a,b) = low 32 bits of ((signed64)a·(signed64)b >>> FRAC_BITS). The shift is arithmetic, i.e. floor rounding.
- Accumulator is 34-bit signed. Final result saturates to [0x80000000, 0x7FFFFFFF].
- State x_cur and x_prev, 32 bits each, reset to 0.
- FSM states: READ, MAC0, MAC1, WRITE. Reset state is READ.
- READ: if !in_empty, assert in_rd_en, set x_prev←x_cur, x_cur←in_dout, acc←0, go to MAC0. Otherwise stay in READ.
- MAC0: acc←acc+mul(x_cur,B0), go to MAC1.
- MAC1: result←sat(acc+mul(x_prev,B1)); out_din register loads the result; go to WRITE.
- WRITE, normal: if !out_full, assert out_wr_en.
  - Same cycle, if !in_empty, also assert in_rd_en, perform the READ update, and go to MAC0 (back-to-back path).
  - Same cycle, if in_empty, go to READ.
- WRITE, stalled: if out_full, deassert both enables and hold WRITE. out_din stays stable while stalled.
- in_rd_en is never asserted outside READ and WRITE. out_wr_en is never asserted outside WRITE.
- Exactly one output is produced per input sample, with no decimation and no drop.

## Timing
- Reset values: in_rd_en=0, out_wr_en=0, out_din=0, acc=0, x_cur=x_prev=0, state READ.
- Reset is asynchronous. Asserting it mid-operation discards any in-flight sample and history. The first output after reset uses x[n-1]=0.
- Latency: a pop in READ at cycle t makes out_din valid and out_wr_en high at cycle t+3, provided out_full=0.
- Steady-state throughput is one sample per 3 cycles when the input is non-empty and the output is not full. With an empty-gap path through READ it is one sample per 4 cycles.
- in_rd_en and in_dout are sampled in the same cycle; the FIFO must present data combinationally.
- Simultaneous out_full=1 and in_empty=0 in WRITE: no read. Backpressure must not consume input.
- out_full deasserting mid-stall: write occurs in that same cycle.

## Test plan
- Reset, then input 1024: output 1024 (mul(1024,1024)=1024, previous sample 0); out_wr_en exactly 3 cycles after in_rd_en.
- Inputs 1024, 1024: outputs 1024, 358. Then input -2048: output -2714.
- Rounding: after reset, inputs 1, 1: outputs 1, 0 (mul(1,-666) floors to -1).
- Saturation: inputs 0x80000000, 0x7FFFFFFF: second output clamps to 0x7FFFFFFF. Inputs 0x7FFFFFFF, 0x80000000: second output 0x80000000-range saturated low.
- Backpressure: hold out_full=1 for 10 cycles in WRITE with the input non-empty. Required: no in_rd_en, out_din stable, and one write when out_full drops. The stream of 100 random samples matches the reference model in order.
- Reset asserted during MAC1: all outputs 0 immediately. The next sample is filtered with x[n-1]=0.
